// File: rtl/hud_text_sequencer.sv
// HUD text sequencer: on each entry to vertical blanking, snapshots health and game
// state and streams 30 font-cell writes (two health readouts plus a status message).
module hud_text_sequencer #(
    parameter int          VBLANK_LINE = 514,
    parameter logic [15:0] HUD_COLOR   = 16'hF83F,
    parameter logic [15:0] MSG_COLOR   = 16'hFFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  v_count,
    input  logic [3:0]  player1_health,
    input  logic [3:0]  player2_health,
    input  logic [1:0]  game_state,
    output logic        write_font,
    output logic [12:0] font_addr,
    output logic [6:0]  font_id,
    output logic [15:0] font_color_mask,
    output logic [1:0]  font_scale,
    output logic        busy,
    output logic        frame_done
);

    localparam logic [9:0] VBL       = 10'(VBLANK_LINE);
    localparam logic [4:0] LAST_IDX  = 5'd29;

    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

    state_t      state, state_nxt;
    logic [4:0]  idx, idx_nxt;
    logic [3:0]  snap_p1, snap_p2;
    logic [1:0]  snap_gs;
    logic        blank, blank_q, trigger;

    logic [12:0] cell_addr;
    logic [6:0]  cell_id;
    logic        cell_msg;
    logic [4:0]  off8, off16;

    assign blank   = (v_count >= VBL);
    assign trigger = blank & ~blank_q;
    assign off8    = idx - 5'd8;
    assign off16   = idx - 5'd16;

    function automatic logic [6:0] tens_char(input logic [3:0] h);
        return (h >= 4'd10) ? 7'd49 : 7'd32;
    endfunction

    function automatic logic [6:0] units_char(input logic [3:0] h);
        logic [3:0] u;
        u = (h >= 4'd10) ? (h - 4'd10) : h;
        return 7'd48 + {3'b000, u};
    endfunction

    // "Pn HP:" label, n selected by p2
    function automatic logic [6:0] label_char(input logic [2:0] k, input logic p2);
        logic [6:0] c;
        case (k)
            3'd0:    c = 7'd80;
            3'd1:    c = p2 ? 7'd50 : 7'd49;
            3'd2:    c = 7'd32;
            3'd3:    c = 7'd72;
            3'd4:    c = 7'd80;
            3'd5:    c = 7'd58;
            default: c = 7'd32;
        endcase
        return c;
    endfunction

    function automatic logic [6:0] msg_char(input logic [1:0] gs, input logic [3:0] pos);
        logic [6:0] c;
        c = 7'd32;
        if (gs == 2'd0) begin
            case (pos)
                4'd0:  c = 7'd80;
                4'd1:  c = 7'd82;
                4'd2:  c = 7'd69;
                4'd3:  c = 7'd83;
                4'd4:  c = 7'd83;
                4'd6:  c = 7'd83;
                4'd7:  c = 7'd84;
                4'd8:  c = 7'd65;
                4'd9:  c = 7'd82;
                4'd10: c = 7'd84;
                default: c = 7'd32;
            endcase
        end else if (gs != 2'd1) begin
            case (pos)
                4'd0:  c = 7'd80;
                4'd1:  c = 7'd76;
                4'd2:  c = 7'd65;
                4'd3:  c = 7'd89;
                4'd4:  c = 7'd69;
                4'd5:  c = 7'd82;
                4'd7:  c = (gs == 2'd2) ? 7'd49 : 7'd50;
                4'd9:  c = 7'd87;
                4'd10: c = 7'd73;
                4'd11: c = 7'd78;
                4'd12: c = 7'd83;
                default: c = 7'd32;
            endcase
        end
        return c;
    endfunction

    // Cell decode from idx and snapshot only
    always_comb begin
        cell_addr = 13'd0;
        cell_id   = 7'd32;
        cell_msg  = 1'b0;
        if (idx < 5'd6) begin
            cell_addr = {8'd0, idx};
            cell_id   = label_char(idx[2:0], 1'b0);
        end else if (idx == 5'd6) begin
            cell_addr = 13'd6;
            cell_id   = tens_char(snap_p1);
        end else if (idx == 5'd7) begin
            cell_addr = 13'd7;
            cell_id   = units_char(snap_p1);
        end else if (idx < 5'd14) begin
            cell_addr = 13'd72 + {8'd0, off8};
            cell_id   = label_char(off8[2:0], 1'b1);
        end else if (idx == 5'd14) begin
            cell_addr = 13'd78;
            cell_id   = tens_char(snap_p2);
        end else if (idx == 5'd15) begin
            cell_addr = 13'd79;
            cell_id   = units_char(snap_p2);
        end else begin
            cell_addr = 13'd1153 + {8'd0, off16};
            cell_id   = msg_char(snap_gs, off16[3:0]);
            cell_msg  = 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        case (state)
            IDLE: begin
                if (trigger) begin
                    state_nxt = WRITE;
                    idx_nxt   = 5'd0;
                end
            end
            WRITE: begin
                if (idx == LAST_IDX) begin
                    state_nxt = DONE;
                    idx_nxt   = 5'd0;
                end else begin
                    idx_nxt = idx + 5'd1;
                end
            end
            DONE: begin
                if (!blank) state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                idx_nxt   = 5'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            idx             <= 5'd0;
            snap_p1         <= 4'd0;
            snap_p2         <= 4'd0;
            snap_gs         <= 2'd0;
            blank_q         <= 1'b1;
            write_font      <= 1'b0;
            font_addr       <= 13'd0;
            font_id         <= 7'd0;
            font_color_mask <= 16'd0;
            font_scale      <= 2'd0;
            busy            <= 1'b0;
            frame_done      <= 1'b0;
        end else begin
            blank_q <= blank;
            state   <= state_nxt;
            idx     <= idx_nxt;
            if (state == IDLE && trigger) begin
                snap_p1 <= player1_health;
                snap_p2 <= player2_health;
                snap_gs <= game_state;
            end
            write_font <= (state == WRITE);
            busy       <= (state == WRITE);
            // write_font still high here means this is the first DONE cycle
            frame_done <= (state == DONE) && write_font;
            if (state == WRITE) begin
                font_addr       <= cell_addr;
                font_id         <= cell_id;
                font_color_mask <= cell_msg ? MSG_COLOR : HUD_COLOR;
                font_scale      <= cell_msg ? 2'd1 : 2'd0;
            end
        end
    end

endmodule

// File: tb/tb_hud_text_sequencer.sv
// Scoreboard bench for hud_text_sequencer: frames push expected cells, a negedge
// monitor pops and compares every strobe and frame_done pulse.
module tb_hud_text_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  v_count;
    logic [3:0]  p1, p2;
    logic [1:0]  gs;
    logic        write_font, busy, frame_done;
    logic [12:0] font_addr;
    logic [6:0]  font_id;
    logic [15:0] font_color_mask;
    logic [1:0]  font_scale;

    int asserts = 0;
    int fails   = 0;
    int cyc     = 0;

    typedef struct {
        int addr;
        int id;
        int mask;
        int scale;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   done_q[$];

    hud_text_sequencer dut (
        .clk(clk), .reset(reset), .v_count(v_count),
        .player1_health(p1), .player2_health(p2), .game_state(gs),
        .write_font(write_font), .font_addr(font_addr), .font_id(font_id),
        .font_color_mask(font_color_mask), .font_scale(font_scale),
        .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        asserts++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t mk(input int k, input int h1, input int h2, input int g, input int c);
        exp_t  e;
        string l1, l2;
        string m[4];
        l1 = "P1 HP:";
        l2 = "P2 HP:";
        m[0] = "PRESS START   ";
        m[1] = "              ";
        m[2] = "PLAYER 1 WINS ";
        m[3] = "PLAYER 2 WINS ";
        e.cyc   = c;
        e.mask  = 'hF83F;
        e.scale = 0;
        if (k < 6) begin
            e.addr = k;       e.id = int'(l1[k]);
        end else if (k == 6) begin
            e.addr = 6;       e.id = (h1 / 10 != 0) ? 49 : 32;
        end else if (k == 7) begin
            e.addr = 7;       e.id = 48 + h1 % 10;
        end else if (k < 14) begin
            e.addr = 72 + (k - 8); e.id = int'(l2[k - 8]);
        end else if (k == 14) begin
            e.addr = 78;      e.id = (h2 / 10 != 0) ? 49 : 32;
        end else if (k == 15) begin
            e.addr = 79;      e.id = 48 + h2 % 10;
        end else begin
            e.addr  = 1153 + (k - 16);
            e.id    = int'(m[g][k - 16]);
            e.mask  = 'hFFFF;
            e.scale = 1;
        end
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        int   dc;
        if (write_font === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_write", int'(font_addr), -1);
            end else begin
                e = sb.pop_front();
                chk("wr_cycle", cyc, e.cyc);
                chk("addr", int'(font_addr), e.addr);
                chk("id", int'(font_id), e.id);
                chk("mask", int'(font_color_mask), e.mask);
                chk("scale", int'(font_scale), e.scale);
                chk("busy", int'(busy), 1);
            end
        end
        if (frame_done === 1'b1) begin
            if (done_q.size() == 0) begin
                chk("unexpected_done", cyc, -1);
            end else begin
                dc = done_q.pop_front();
                chk("done_cycle", cyc, dc);
                chk("done_wr_low", int'(write_font), 0);
                chk("done_busy_low", int'(busy), 0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One blanking interval; chg_p1 >= 0 rewrites player1_health at T+3
    task automatic frame(input int h1, input int h2, input int g, input int hold,
                         input int chg_p1, input bit do_reset);
        int t, n;
        v_count = 10'd0;
        p1 = 4'(h1);
        p2 = 4'(h2);
        gs = 2'(g);
        repeat (3) step();
        for (int v = 505; v < 514; v++) begin
            v_count = 10'(v);
            step();
        end
        v_count = 10'd514;
        t = cyc + 1;
        n = do_reset ? 9 : 30;
        for (int k = 0; k < n; k++) sb.push_back(mk(k, h1, h2, g, t + 1 + k));
        if (!do_reset) done_q.push_back(t + 31);
        for (int i = 0; i < 6 + hold; i++) begin
            step();
            if (chg_p1 >= 0 && cyc == t + 3) p1 = 4'(chg_p1);
            if (do_reset && cyc == t + 9) reset = 1'b1;
            if (do_reset && cyc == t + 11) reset = 1'b0;
            if (v_count < 10'd520) v_count = v_count + 10'd1;
        end
        v_count = 10'd0;
        repeat (40) step();
    endtask

    initial begin
        reset   = 1'b1;
        v_count = 10'd0;
        p1 = 4'd0;
        p2 = 4'd0;
        gs = 2'd0;
        repeat (3) step();
        @(negedge clk);
        chk("rst_write_font", int'(write_font), 0);
        chk("rst_addr", int'(font_addr), 0);
        chk("rst_id", int'(font_id), 0);
        chk("rst_mask", int'(font_color_mask), 0);
        chk("rst_scale", int'(font_scale), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(frame_done), 0);
        step();
        reset = 1'b0;

        frame(5, 12, 1, 30, -1, 1'b0);   // nominal: 32/53, 49/50, blank message
        frame(0, 9, 3, 30, -1, 1'b0);    // P2 wins; digits 32/48 and 32/57
        frame(10, 15, 2, 0, -1, 1'b0);   // short blanking; 49/48 and 49/53
        frame(3, 7, 0, 30, 7, 1'b0);     // mid-list change ignored: idx7 = 51
        frame(7, 7, 0, 30, -1, 1'b0);    // next frame shows 55
        frame(4, 4, 1, 20, -1, 1'b1);    // reset at T+10, release in blanking
        frame(1, 2, 2, 10, -1, 1'b0);    // recovers on next blanking entry
        frame(11, 6, 3, 200, -1, 1'b0);  // long blanking: one burst only

        chk("sb_drained", sb.size(), 0);
        chk("done_drained", done_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
